// File: rtl/spi_read_buffer.sv
// spi_read_buffer: packet FIFO feeding the SPI file loader.
// Entries are {last, data[31:0]}; the head entry falls through to spi_data.
// After a last-flagged word is accepted, input stays blocked until the loader
// pops that word, so only one file is ever in flight.
// Optional macro SPI_RB_WORD_COUNT_EN enables the popped-word counter on word_cnt.
module spi_read_buffer #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic        rb_ready,
  output logic [31:0] spi_data,
  output logic        r_valid_o,
  output logic        r_last_o,
  output logic [AW:0] level,
  output logic        underflow,
  output logic [31:0] word_cnt
);

  localparam logic [0:0]    ST_LOAD  = 1'b0;
  localparam logic [0:0]    ST_HOLD  = 1'b1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [0:0]    state_q, state_d;
  logic          underflow_q, underflow_d;

  logic [32:0]   head;
  logic          full;
  logic          push;
  logic          pop;

  assign head      = mem_q[rd_ptr_q];
  assign full      = (level_q == LVL_FULL);
  // Gated by rst so the stream side sees "not ready" while reset is held.
  assign s_tready  = ~rst & (state_q == ST_LOAD) & ~full;
  assign r_valid_o = (level_q != '0);
  assign push      = s_tvalid & s_tready;
  // A pop needs a stored word, so a push into an empty FIFO is never popped in the same cycle.
  assign pop       = rb_ready & r_valid_o;

  assign spi_data  = r_valid_o ? head[31:0] : 32'h0;
  assign r_last_o  = r_valid_o & head[32];
  assign level     = level_q;
  assign underflow = underflow_q;

  // Storage write; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
    end
  end

  // Next-state logic for pointers, level, file state and sticky underflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    state_d     = state_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      state_d     = ST_LOAD;
      underflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop) begin
        level_d = level_q + LVL_ONE;
      end else if (pop && !push) begin
        level_d = level_q - LVL_ONE;
      end
      if (rb_ready && !r_valid_o) underflow_d = 1'b1;
      if (state_q == ST_LOAD) begin
        if (push && s_tlast) state_d = ST_HOLD;
      end else begin
        if (pop && head[32]) state_d = ST_LOAD;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= ST_LOAD;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SPI_RB_WORD_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;

  // Count pops in the current file; after the last word the final count is shown
  // for one cycle, then cleared (or restarted at 1 if another pop follows at once).
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (flush) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (pop) begin
      cnt_d  = done_q ? 32'd1 : cnt_q + 32'd1;
      done_d = head[32];
    end else if (done_q) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign word_cnt = cnt_q;
`else
  assign word_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_spi_read_buffer.sv
// Directed testbench for spi_read_buffer (DEPTH=16).
module tb_spi_read_buffer;

`ifdef SPI_RB_WORD_COUNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, s_tvalid, s_tlast, rb_ready;
  logic [31:0] s_tdata, spi_data, word_cnt;
  logic        s_tready, r_valid_o, r_last_o, underflow;
  logic [4:0]  level;

  int n_cmp = 0;
  int n_err = 0;

  spi_read_buffer #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .rb_ready(rb_ready), .spi_data(spi_data), .r_valid_o(r_valid_o), .r_last_o(r_last_o),
    .level(level), .underflow(underflow), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; rb_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready_during: got %b want 0", s_tready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready: got %b want 1", s_tready); end
    n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", r_valid_o); end
    n_cmp++; if (spi_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", spi_data); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow: got %b want 0", underflow); end
    n_cmp++; if (word_cnt !== 32'h0) begin n_err++; $display("FAIL rst_wcnt: got %0d want 0", word_cnt); end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_file();
    logic [31:0] exp_d;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hA000_0001 + i; s_tlast = (i == 2);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_cmp++; if (level !== 5'd3) begin n_err++; $display("FAIL file_level: got %0d want 3", level); end
    n_cmp++; if (spi_data !== 32'hA000_0001) begin n_err++; $display("FAIL file_head: got %h want a0000001", spi_data); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL file_hold: got %b want 0", s_tready); end
    rb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_d = 32'hA000_0001 + i;
      n_cmp++; if (spi_data !== exp_d) begin n_err++; $display("FAIL file_pop_data%0d: got %h want %h", i, spi_data, exp_d); end
      n_cmp++; if (r_last_o !== (i == 2)) begin n_err++; $display("FAIL file_pop_last%0d: got %b want %b", i, r_last_o, (i == 2)); end
      tick();
    end
    rb_ready = 1'b0;
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL file_end_level: got %0d want 0", level); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL file_end_tready: got %b want 1", s_tready); end
    n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL file_end_valid: got %b want 0", r_valid_o); end
    $display("test_file done");
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hB000_0000 + i; s_tlast = 1'b0;
      tick();
    end
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d want 16", level); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b want 0", s_tready); end
    // Offer a word while full together with a pop: only the pop may happen.
    s_tdata = 32'hDEAD_0000; rb_ready = 1'b1;
    n_cmp++; if (spi_data !== 32'hB000_0000) begin n_err++; $display("FAIL full_head: got %h want b0000000", spi_data); end
    tick();
    n_cmp++; if (level !== 5'd15) begin n_err++; $display("FAIL full_pop_level: got %0d want 15", level); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL full_pop_tready: got %b want 1", s_tready); end
    for (int k = 0; k < 4; k++) begin
      s_tdata = 32'hB000_0010 + k;
      exp_d = 32'hB000_0001 + k;
      n_cmp++; if (spi_data !== exp_d) begin n_err++; $display("FAIL wrap_pp_data%0d: got %h want %h", k, spi_data, exp_d); end
      tick();
    end
    s_tvalid = 1'b0;
    n_cmp++; if (level !== 5'd15) begin n_err++; $display("FAIL wrap_level: got %0d want 15", level); end
    for (int k = 5; k < 20; k++) begin
      exp_d = 32'hB000_0000 + k;
      n_cmp++; if (spi_data !== exp_d) begin n_err++; $display("FAIL wrap_drain%0d: got %h want %h", k, spi_data, exp_d); end
      tick();
    end
    rb_ready = 1'b0;
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL wrap_end_level: got %0d want 0", level); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL wrap_underflow: got %b want 0", underflow); end
    $display("test_full_wrap done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hC000_0000 + i; s_tlast = 1'b0;
      tick();
    end
    rb_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_tdata = 32'hC000_0002 + k;
      exp_d = 32'hC000_0000 + k;
      n_cmp++; if (spi_data !== exp_d) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", k, spi_data, exp_d); end
      tick();
      n_cmp++; if (level !== 5'd2) begin n_err++; $display("FAIL b2b_level%0d: got %0d want 2", k, level); end
    end
    s_tvalid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      exp_d = 32'hC000_0000 + k;
      n_cmp++; if (spi_data !== exp_d) begin n_err++; $display("FAIL b2b_drain%0d: got %h want %h", k, spi_data, exp_d); end
      tick();
    end
    rb_ready = 1'b0;
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL b2b_end_level: got %0d want 0", level); end
    $display("test_back_to_back done");
  endtask

  task automatic test_underflow_flush();
    rb_ready = 1'b1;
    tick();
    rb_ready = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set: got %b want 1", underflow); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL uf_level: got %0d want 0", level); end
    s_tvalid = 1'b1; s_tdata = 32'hE000_0000; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL uf_hold: got %b want 0", s_tready); end
    n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL uf_push_level: got %0d want 1", level); end
    // Flush with a pop request pending: the pop must be ignored.
    flush = 1'b1; rb_ready = 1'b1;
    tick();
    flush = 1'b0; rb_ready = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL flush_uf: got %b want 0", underflow); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL flush_tready: got %b want 1", s_tready); end
    n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", r_valid_o); end
    n_cmp++; if (word_cnt !== 32'h0) begin n_err++; $display("FAIL flush_wcnt: got %0d want 0", word_cnt); end
    $display("test_underflow_flush done");
  endtask

  task automatic test_word_count();
    logic [31:0] exp_c;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hF000_0000 + i; s_tlast = (i == 3);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    rb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_c = WC_EN ? 32'(i + 1) : 32'h0;
      n_cmp++; if (word_cnt !== exp_c) begin n_err++; $display("FAIL wcnt%0d: got %0d want %0d", i, word_cnt, exp_c); end
    end
    rb_ready = 1'b0;
    tick();
    n_cmp++; if (word_cnt !== 32'h0) begin n_err++; $display("FAIL wcnt_clear: got %0d want 0", word_cnt); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL wcnt_tready: got %b want 1", s_tready); end
    $display("test_word_count done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_c;
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'h5000_0000 + i; s_tlast = 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    rb_ready = 1'b1;
    tick(); tick();
    rb_ready = 1'b0;
    exp_c = WC_EN ? 32'd2 : 32'h0;
    n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL mid_level: got %0d want 5", level); end
    n_cmp++; if (word_cnt !== exp_c) begin n_err++; $display("FAIL mid_wcnt: got %0d want %0d", word_cnt, exp_c); end
    rst = 1'b1;
    #1;
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL arst_level: got %0d want 0", level); end
    n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", r_valid_o); end
    n_cmp++; if (spi_data !== 32'h0) begin n_err++; $display("FAIL arst_data: got %h want 0", spi_data); end
    n_cmp++; if (r_last_o !== 1'b0) begin n_err++; $display("FAIL arst_last: got %b want 0", r_last_o); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL arst_tready: got %b want 0", s_tready); end
    n_cmp++; if (word_cnt !== 32'h0) begin n_err++; $display("FAIL arst_wcnt: got %0d want 0", word_cnt); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL arst_rel_tready: got %b want 1", s_tready); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL arst_rel_level: got %0d want 0", level); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_file();
    test_full_wrap();
    test_back_to_back();
    test_underflow_flush();
    test_word_count();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
